// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control token codes, receiver state encoding and
// the token <-> control-bit mapping used by both the encoder and the receiver.
package tmds_pkg;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic       is_token;
    logic [1:0] ctl;
  } token_hit_t;

  function automatic token_hit_t token_lookup(input logic [9:0] q);
    token_hit_t r;
    r = '0;
    case (q)
      TOKEN_C00: r = '{is_token: 1'b1, ctl: 2'b00};
      TOKEN_C01: r = '{is_token: 1'b1, ctl: 2'b01};
      TOKEN_C10: r = '{is_token: 1'b1, ctl: 2'b10};
      TOKEN_C11: r = '{is_token: 1'b1, ctl: 2'b11};
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [9:0] ctl_to_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOKEN_C00;
      2'b01:   t = TOKEN_C01;
      2'b10:   t = TOKEN_C10;
      default: t = TOKEN_C11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_word_decoder.sv
// Combinational TMDS word decoder: 10-bit symbol q to token flag,
// control bits and 8-bit data byte.
module tmds_word_decoder
  import tmds_pkg::*;
(
  input  logic [9:0] q,
  output logic       is_token,
  output logic [1:0] ctl,
  output logic [7:0] data
);

  token_hit_t hit;
  logic [7:0] t;

  always_comb begin
    hit      = token_lookup(q);
    is_token = hit.is_token;
    ctl      = hit.ctl;
    t        = q[9] ? ~q[7:0] : q[7:0];
    data     = '0;
    data[0]  = t[0];
    for (int unsigned i = 1; i < 8; i++) begin
      data[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

endmodule

// File: rtl/tmds_deserializer_decoder.sv
// TMDS receiver lane: bit shifting, token-based word alignment and decode.
// Optional error counter enabled by defining TMDS_RX_ERRCNT_EN.
module tmds_deserializer_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_TOKENS = 4,
  parameter int unsigned LOSS_WORDS  = 4096
) (
  input  logic       serialClock,
  input  logic       resetN,
  input  logic       tmdsSerialIn,
  output logic [7:0] pixelComponent,
  output logic [1:0] controlBus,
  output logic       DE,
  output logic       wordValid,
  output logic       locked
`ifdef TMDS_RX_ERRCNT_EN
  ,
  output logic [15:0] errorCount
`endif
);

  localparam int unsigned TOK_W  = $clog2(LOCK_TOKENS + 1);
  localparam int unsigned LOSS_W = $clog2(LOSS_WORDS + 1);

  rx_state_e   state_q, state_d;
  logic [9:0]  sr_q, sr_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [TOK_W-1:0]  tok_cnt_q, tok_cnt_d;
  logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
  logic [7:0]  pix_q, pix_d;
  logic [1:0]  ctl_q, ctl_d;
  logic        de_q, de_d;
  logic        word_valid_q, word_valid_d;
  logic        locked_q, locked_d;
  logic        err_fire;
  logic        boundary;

  logic        dec_is_token;
  logic [1:0]  dec_ctl;
  logic [7:0]  dec_data;

  tmds_word_decoder u_word_decoder (
    .q        (sr_q),
    .is_token (dec_is_token),
    .ctl      (dec_ctl),
    .data     (dec_data)
  );

  always_comb begin
    sr_d         = {tmdsSerialIn, sr_q[9:1]};
    boundary     = (bit_cnt_q == 4'd9);
    bit_cnt_d    = boundary ? 4'd0 : bit_cnt_q + 4'd1;
    state_d      = state_q;
    tok_cnt_d    = tok_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    pix_d        = pix_q;
    ctl_d        = ctl_q;
    de_d         = de_q;
    word_valid_d = 1'b0;
    err_fire     = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        if (dec_is_token) begin
          bit_cnt_d = 4'd0;
          tok_cnt_d = TOK_W'(1);
          state_d   = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (boundary) begin
          if (dec_is_token) begin
            tok_cnt_d = tok_cnt_q + TOK_W'(1);
            if (tok_cnt_d == TOK_W'(LOCK_TOKENS)) begin
              state_d    = ST_LOCKED;
              loss_cnt_d = '0;
            end
          end else begin
            state_d   = ST_SEARCH;
            tok_cnt_d = '0;
            err_fire  = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (boundary) begin
          word_valid_d = 1'b1;
          de_d         = ~dec_is_token;
          // A token always refreshes lock, even on the word that would hit the loss limit.
          if (dec_is_token) begin
            ctl_d      = dec_ctl;
            loss_cnt_d = '0;
          end else begin
            pix_d      = dec_data;
            loss_cnt_d = loss_cnt_q + LOSS_W'(1);
            if (loss_cnt_d == LOSS_W'(LOSS_WORDS)) begin
              state_d    = ST_SEARCH;
              loss_cnt_d = '0;
              tok_cnt_d  = '0;
              err_fire   = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge serialClock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_SEARCH;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      tok_cnt_q    <= '0;
      loss_cnt_q   <= '0;
      pix_q        <= '0;
      ctl_q        <= '0;
      de_q         <= 1'b0;
      word_valid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      tok_cnt_q    <= tok_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      pix_q        <= pix_d;
      ctl_q        <= ctl_d;
      de_q         <= de_d;
      word_valid_q <= word_valid_d;
      locked_q     <= locked_d;
    end
  end

  assign pixelComponent = pix_q;
  assign controlBus     = ctl_q;
  assign DE             = de_q;
  assign wordValid      = word_valid_q;
  assign locked         = locked_q;

`ifdef TMDS_RX_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_fire && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge serialClock or negedge resetN) begin
    if (!resetN) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign errorCount = err_cnt_q;
`endif

endmodule

// File: tb/tb_tmds_deserializer_decoder.sv
// Directed bench for the TMDS receiver lane: lock, decode, token mapping,
// loss of lock, asynchronous reset and VERIFY failure.
module tb_tmds_deserializer_decoder;

  localparam int unsigned LOCK_T = 4;
  localparam int unsigned LOSS_W = 8;

  localparam logic [9:0] T0  = 10'b1101010100;
  localparam logic [9:0] T1  = 10'b0010101011;
  localparam logic [9:0] T2  = 10'b0101010100;
  localparam logic [9:0] T3  = 10'b1010101011;
  localparam logic [9:0] D55 = 10'b0100110011;  // balanced encoding of 8'h55
  localparam logic [9:0] DAB = 10'b1011001100;  // inverted/XNOR form decoding to 8'hAB

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin = 1'b0;
  logic [7:0] pix;
  logic [1:0] ctl;
  logic       de;
  logic       wv;
  logic       lck;
`ifdef TMDS_RX_ERRCNT_EN
  logic [15:0] errorCount;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic       cap_wv, cap_de, cap_lock;
  logic [7:0] cap_pix;
  logic [1:0] cap_ctl;
  int         cap_wvcnt;
  logic [15:0] cap_err;

  tmds_deserializer_decoder #(.LOCK_TOKENS(LOCK_T), .LOSS_WORDS(LOSS_W)) dut (
    .serialClock    (clk),
    .resetN         (rst_n),
    .tmdsSerialIn   (sin),
    .pixelComponent (pix),
    .controlBus     (ctl),
    .DE             (de),
    .wordValid      (wv),
    .locked         (lck)
`ifdef TMDS_RX_ERRCNT_EN
    ,
    .errorCount     (errorCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  // Sends one word LSB first; snapshots outputs one cycle into the word,
  // which reflects the boundary of the previous word.
  task automatic send_word(input logic [9:0] q);
    cap_wvcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step_bit(q[i]);
      if (wv === 1'b1) cap_wvcnt++;
      if (i == 0) begin
        cap_wv   = wv;
        cap_de   = de;
        cap_pix  = pix;
        cap_ctl  = ctl;
        cap_lock = lck;
`ifdef TMDS_RX_ERRCNT_EN
        cap_err  = errorCount;
`else
        cap_err  = '0;
`endif
      end
    end
  endtask

  task automatic do_reset();
    sin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step_bit(1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix"}, 16'(pix), 16'h0);
    chk({tag, "_ctl"}, 16'(ctl), 16'h0);
    chk({tag, "_de"},  16'(de),  16'h0);
    chk({tag, "_wv"},  16'(wv),  16'h0);
    chk({tag, "_lck"}, 16'(lck), 16'h0);
`ifdef TMDS_RX_ERRCNT_EN
    chk({tag, "_err"}, errorCount, 16'h0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    do_reset();

    // Lock on six T0 words, three bits after reset release
    send_word(T0);
    send_word(T0);
    send_word(T0);
    send_word(T0);
    chk("lock_pre", 16'(cap_lock), 16'h0);
    send_word(T0);
    chk("lock_rise", 16'(cap_lock), 16'h1);
    chk("no_wv_verify", 16'(cap_wvcnt), 16'h0);
    send_word(T0);
    chk("first_wv", 16'(cap_wv), 16'h1);
    chk("first_de", 16'(cap_de), 16'h0);
    chk("first_ctl", 16'(cap_ctl), 16'h0);
    chk("first_cnt", 16'(cap_wvcnt), 16'h1);

    // Data words
    send_word(D55);
    send_word(D55);
    chk("d55_wv", 16'(cap_wv), 16'h1);
    chk("d55_de", 16'(cap_de), 16'h1);
    chk("d55_pix", 16'(cap_pix), 16'h55);
    chk("d55_ctl_hold", 16'(cap_ctl), 16'h0);
    chk("d55_cnt", 16'(cap_wvcnt), 16'h1);
    send_word(DAB);
    chk("d55_pix2", 16'(cap_pix), 16'h55);
    chk("d55_cnt2", 16'(cap_wvcnt), 16'h1);
    send_word(T1);
    chk("dab_pix", 16'(cap_pix), 16'hAB);
    chk("dab_de", 16'(cap_de), 16'h1);

    // All four tokens while locked
    send_word(T2);
    chk("t1_ctl", 16'(cap_ctl), 16'h1);
    chk("t1_de", 16'(cap_de), 16'h0);
    chk("t1_pix_hold", 16'(cap_pix), 16'hAB);
    send_word(T3);
    chk("t2_ctl", 16'(cap_ctl), 16'h2);
    send_word(T0);
    chk("t3_ctl", 16'(cap_ctl), 16'h3);
    send_word(D55);
    chk("t0_ctl", 16'(cap_ctl), 16'h0);
    chk("t0_wv", 16'(cap_wv), 16'h1);

    // Asynchronous reset at bit 5 of a locked word
    for (int i = 0; i < 5; i++) step_bit(D55[i]);
    sin = D55[5];
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step_bit(1'b0);

    // Relock and check a token after relock
    send_word(T0);
    send_word(T0);
    send_word(T0);
    send_word(T0);
    send_word(T3);
    chk("relock", 16'(cap_lock), 16'h1);
    send_word(T0);
    chk("relock_ctl", 16'(cap_ctl), 16'h3);
    chk("relock_wv", 16'(cap_wv), 16'h1);

    // LOSS_W-1 data words then a token: lock holds
    for (int w = 0; w < LOSS_W - 1; w++) send_word(D55);
    send_word(T0);
    chk("loss_m1_lock", 16'(cap_lock), 16'h1);
    send_word(D55);
    chk("loss_tok_lock", 16'(cap_lock), 16'h1);
    chk("loss_tok_de", 16'(cap_de), 16'h0);

    // LOSS_W data words: lock falls after the last boundary
    for (int w = 0; w < LOSS_W - 1; w++) send_word(D55);
    chk("loss_last_lock", 16'(cap_lock), 16'h1);
    send_word(D55);
    chk("loss_drop", 16'(cap_lock), 16'h0);
`ifdef TMDS_RX_ERRCNT_EN
    chk("loss_errcnt", cap_err, 16'h1);
`endif

    // VERIFY failure: tokens then a data word
    do_reset();
    send_word(T0);
    send_word(T1);
    send_word(T2);
    send_word(D55);
    chk("vfail_lock_pre", 16'(cap_lock), 16'h0);
    send_word(10'h000);
    chk("vfail_lock", 16'(cap_lock), 16'h0);
    chk("vfail_nowv", 16'(cap_wvcnt), 16'h0);
`ifdef TMDS_RX_ERRCNT_EN
    chk("vfail_errcnt", cap_err, 16'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
